// File: rtl/cpu_pkg.sv
// Shared core-wide constants and types used by the fetch front end.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int INST_WIDTH = 32;
  localparam int PC_STEP    = 4;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer of {pc, inst} entries; synchronous flush, async reset.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(cpu_pkg::fetch_entry_t)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && (!full || pop);
  assign do_pop    = pop && !empty;

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: empty entries are never presented.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: owns the PC, issues credit-limited imem requests,
// buffers tagged instructions and squashes in-flight responses on redirect.
module fetch_unit #(
  parameter int                     XLEN         = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0]        RESET_VECTOR = cpu_pkg::RESET_VECTOR,
  parameter int                     DEPTH        = 4,
  parameter int                     MAX_OUT      = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic                              imem_req_valid,
  input  logic                              imem_req_ready,
  output logic [XLEN-1:0]                   imem_req_addr,
  input  logic                              imem_rsp_valid,
  input  logic [cpu_pkg::INST_WIDTH-1:0]    imem_rsp_data,
  output logic                              inst_valid,
  input  logic                              inst_ready,
  output logic [cpu_pkg::INST_WIDTH-1:0]    inst_data,
  output logic [XLEN-1:0]                   inst_pc,
  input  logic                              redirect_valid,
  input  logic [XLEN-1:0]                   redirect_target,
  output logic                              misalign_err,
  output logic [$clog2(MAX_OUT+1)-1:0]      outstanding
);

  import cpu_pkg::*;

  localparam int CW = $clog2(MAX_OUT+1);
  localparam int FW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + INST_WIDTH;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   live_cnt_q, live_cnt_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            halted_q, halted_d;
  logic [CW-1:0]   inflight;
  logic            credit_ok, req_fire, rsp_drop, rsp_live;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]   fifo_count;
  logic [EW-1:0]   fifo_head;

  // Live requests reserve a buffer slot, so a kept response always finds room.
  assign inflight  = live_cnt_q + drop_cnt_q;
  assign credit_ok = ((32'(fifo_count) + 32'(live_cnt_q)) < 32'(DEPTH)) &&
                     (32'(inflight) < 32'(MAX_OUT));

  assign imem_req_valid = !reset && !halted_q && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_live       = imem_rsp_valid && (drop_cnt_q == '0) && (live_cnt_q != '0);

  assign fifo_push    = rsp_live && !redirect_valid && !fifo_full;
  assign fifo_pop     = inst_valid && inst_ready && !redirect_valid;
  assign inst_valid   = !fifo_empty;
  assign inst_pc      = inst_valid ? fifo_head[EW-1 -: XLEN] : '0;
  assign inst_data    = inst_valid ? fifo_head[INST_WIDTH-1:0] : '0;
  assign misalign_err = halted_q;
  assign outstanding  = inflight;

  // PC, credit counter and halt next-state.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    live_cnt_d = live_cnt_q;
    drop_cnt_d = drop_cnt_q;
    halted_d   = halted_q;
    if (redirect_valid) begin
      // Everything still in flight becomes stale; a response landing now is consumed.
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
      live_cnt_d = '0;
      drop_cnt_d = inflight - ((rsp_drop || rsp_live) ? CW'(1) : CW'(0));
      halted_d   = halted_q || (redirect_target[1:0] != 2'b00);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      if (rsp_live) begin
        rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
      end else begin
        rsp_pc_d = rsp_pc_q;
      end
      live_cnt_d = live_cnt_q + (req_fire ? CW'(1) : CW'(0)) - (rsp_live ? CW'(1) : CW'(0));
    end
  end

  // Fetch control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_VECTOR;
      rsp_pc_q   <= RESET_VECTOR;
      live_cnt_q <= '0;
      drop_cnt_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      live_cnt_q <= live_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      halted_q   <= halted_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({rsp_pc_q, imem_rsp_data}),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef SIM
  fetch_unit_chk #(
    .DEPTH   (DEPTH),
    .MAX_OUT (MAX_OUT),
    .CW      (CW),
    .FW      (FW)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .live_cnt (live_cnt_q),
    .drop_cnt (drop_cnt_q),
    .count    (fifo_count)
  );
`endif

endmodule

`ifdef SIM
module fetch_unit_chk #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4,
  parameter int CW      = 3,
  parameter int FW      = 3
) (
  input logic          clk,
  input logic          reset,
  input logic [CW-1:0] live_cnt,
  input logic [CW-1:0] drop_cnt,
  input logic [FW-1:0] count
);
  // Credit invariants that keep every counter within range.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (32'(live_cnt) + 32'(drop_cnt) <= 32'(MAX_OUT))
        else $error("in-flight count exceeds MAX_OUT");
      assert (32'(count) + 32'(live_cnt) <= 32'(DEPTH))
        else $error("buffer credit exceeds DEPTH");
    end
  end
endmodule
`endif

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: imem model with fixed latency, reference model plus
// instruction scoreboard, table-driven vectors and directed redirect/reset cases.
module tb_fetch_unit;

  localparam int          XLEN    = 32;
  localparam int          DEPTH   = 4;
  localparam int          MAX_OUT = 4;
  localparam logic [31:0] RV      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        misalign_err;
  logic [2:0]  outstanding;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .misalign_err(misalign_err), .outstanding(outstanding)
  );

  typedef struct { logic [31:0] addr; int due; bit live; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { bit rst; bit ir; bit rv; logic [31:0] addr; bit iv; logic [31:0] pc; } vec_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  vec_t        tbl[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_rv;
  bit          rsp_now;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Drive this cycle's imem response, then compare DUT outputs with the model.
  task automatic cyc_begin();
    int n_live;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    rsp_now = (pend.size() > 0) && (pend[0].due <= cyc);
    if (rsp_now) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data_of(pend[0].addr);
    end
    #2;
    n_live = 0;
    foreach (pend[i]) if (pend[i].live) n_live++;
    m_rv = !m_halted && !redirect_valid && (exp_q.size() + n_live < DEPTH) && (pend.size() < MAX_OUT);
    check("req_valid", 32'(imem_req_valid), 32'(m_rv));
    if (m_rv) check("req_addr", imem_req_addr, m_pc);
    check("inst_valid", 32'(inst_valid), 32'(exp_q.size() > 0));
    check("outstanding", 32'(outstanding), pend.size());
    check("misalign", 32'(misalign_err), 32'(m_halted));
  endtask

  // Apply the clock edge to the model, scoring any instruction the decoder takes.
  task automatic cyc_end();
    pend_t p;
    exp_t  e;
    if (redirect_valid) begin
      if (rsp_now) p = pend.pop_front();
      foreach (pend[i]) pend[i].live = 1'b0;
      exp_q.delete();
      m_pc = redirect_target;
      if (redirect_target[1:0] != 2'b00) m_halted = 1'b1;
    end else begin
      if (exp_q.size() > 0 && inst_ready) begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst_data", inst_data, e.inst);
      end
      if (rsp_now) begin
        p = pend.pop_front();
        if (p.live) exp_q.push_back('{p.addr, data_of(p.addr)});
      end
      if (m_rv && imem_req_ready) begin
        pend.push_back('{m_pc, cyc + lat, 1'b1});
        m_pc += 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    cyc_begin();
    cyc_end();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    inst_ready = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    pend.delete();
    exp_q.delete();
    m_pc = RV;
    m_halted = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_misalign", 32'(misalign_err), 32'h0);
    check("rst_outstanding", 32'(outstanding), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_pc(input string name, input logic [31:0] want);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc_begin();
      if (inst_valid) begin
        seen = 1'b1;
        check(name, inst_pc, want);
      end
      cyc_end();
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s: no inst_valid within 20 cycles, want pc %h", name, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {rst, inst_ready, req_valid, req_addr, inst_valid, inst_pc} per cycle, 1-cycle imem.
    tbl.push_back('{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h0});
    for (int i = 0; i < 4; i++) tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h8});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'hC});

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        do_reset();
        lat = 1;
      end
      imem_req_ready = 1'b1;
      inst_ready = tbl[i].ir;
      cyc_begin();
      check("tv_req_valid", 32'(imem_req_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) check("tv_req_addr", imem_req_addr, tbl[i].addr);
      check("tv_inst_valid", 32'(inst_valid), 32'(tbl[i].iv));
      if (tbl[i].iv) check("tv_inst_pc", inst_pc, tbl[i].pc);
      cyc_end();
    end

    // Redirect with two stale requests in flight on a 3-cycle imem.
    do_reset();
    lat = 3;
    inst_ready = 1'b1;
    imem_req_ready = 1'b1;
    step();
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    cyc_begin();
    check("t3_outstanding", 32'(outstanding), 32'd2);
    cyc_end();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    cyc_begin();
    check("t3_req_valid", 32'(imem_req_valid), 32'h1);
    check("t3_req_addr", imem_req_addr, 32'h40);
    cyc_end();
    wait_pc("t3_first_pc", 32'h40);

    // Redirect in the same cycle a live response for 0x8 lands, 0xC still in flight.
    do_reset();
    lat = 2;
    inst_ready = 1'b1;
    imem_req_ready = 1'b1;
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_target = 32'h80;
    cyc_begin();
    check("t4_rsp_addr", imem_rsp_data, data_of(32'h8));
    cyc_end();
    redirect_valid = 1'b0;
    cyc_begin();
    check("t4_drop_cnt", 32'(outstanding), 32'd1);
    check("t4_req_addr", imem_req_addr, 32'h80);
    cyc_end();
    wait_pc("t4_first_pc", 32'h80);

    // Misaligned redirect halts fetch until reset.
    do_reset();
    lat = 1;
    inst_ready = 1'b1;
    imem_req_ready = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_target = 32'h42;
    step();
    redirect_valid = 1'b0;
    cyc_begin();
    check("t5_misalign", 32'(misalign_err), 32'h1);
    cyc_end();
    for (int k = 0; k < 20; k++) begin
      cyc_begin();
      check("t5_no_req", 32'(imem_req_valid), 32'h0);
      cyc_end();
    end
    do_reset();
    imem_req_ready = 1'b1;
    cyc_begin();
    check("t5_restart_valid", 32'(imem_req_valid), 32'h1);
    check("t5_restart_addr", imem_req_addr, RV);
    cyc_end();

    // Asynchronous reset with three buffered instructions.
    do_reset();
    lat = 1;
    inst_ready = 1'b0;
    imem_req_ready = 1'b1;
    repeat (3) step();
    imem_req_ready = 1'b0;
    step();
    cyc_begin();
    check("t6_pre_inst_valid", 32'(inst_valid), 32'h1);
    check("t6_pre_req_valid", 32'(imem_req_valid), 32'h1);
    reset = 1'b1;
    #1;
    check("t6_async_inst_valid", 32'(inst_valid), 32'h0);
    check("t6_async_req_valid", 32'(imem_req_valid), 32'h0);
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    cyc_begin();
    check("t6_restart_addr", imem_req_addr, RV);
    cyc_end();
    wait_pc("t6_first_pc", RV);

    // Randomised back-pressure, latency and aligned redirects against the model.
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      lat = $urandom_range(1, 4);
      for (int k = 0; k < 150; k++) begin
        imem_req_ready = ($urandom_range(0, 3) != 0);
        inst_ready = ($urandom_range(0, 2) != 0);
        redirect_valid = ($urandom_range(0, 14) == 0);
        redirect_target = 32'($urandom_range(0, 63)) << 2;
        step();
      end
      redirect_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
